// File: rtl/hc_tx_port_arbiter_if.sv
// hc_tx_port_arbiter_if: requester handshakes, frame timer and shared TX port bundle for the HCTxPort arbiter
interface hc_tx_port_arbiter_if;
    logic       SOFCntlReq, SOFCntlGnt, SOFCntlWEn;
    logic [7:0] SOFCntlData, SOFCntlCntl;
    logic       SendPktReq, SendPktGnt, SendPktWEn;
    logic [7:0] SendPktData, SendPktCntl;
    logic       DirCntlReq, DirCntlGnt, DirCntlWEn;
    logic [7:0] DirCntlData, DirCntlCntl;
    logic [15:0] SOFTimer;
    logic       HCTxPortWEn;
    logic [7:0] HCTxPortData, HCTxPortCntl;
    logic       ArbProtoErr;

    modport master (
        output SOFCntlReq, SOFCntlWEn, SOFCntlData, SOFCntlCntl,
        output SendPktReq, SendPktWEn, SendPktData, SendPktCntl,
        output DirCntlReq, DirCntlWEn, DirCntlData, DirCntlCntl, SOFTimer,
        input  SOFCntlGnt, SendPktGnt, DirCntlGnt,
        input  HCTxPortWEn, HCTxPortData, HCTxPortCntl, ArbProtoErr
    );

    modport slave (
        input  SOFCntlReq, SOFCntlWEn, SOFCntlData, SOFCntlCntl,
        input  SendPktReq, SendPktWEn, SendPktData, SendPktCntl,
        input  DirCntlReq, DirCntlWEn, DirCntlData, DirCntlCntl, SOFTimer,
        output SOFCntlGnt, SendPktGnt, DirCntlGnt,
        output HCTxPortWEn, HCTxPortData, HCTxPortCntl, ArbProtoErr
    );
endinterface

// File: rtl/hc_tx_port_arbiter.sv
// hc_tx_port_arbiter: fixed-priority owner of HCTxPort (SOF > SendPkt > DirCntl); define HC_TX_ARB_SOF_GUARD_EN to hold off new sender grants near frame end
module hc_tx_port_arbiter #(
    parameter logic [15:0] SOF_GUARD_START = 16'hB800
) (
    input logic               clk,
    input logic               rst,
    hc_tx_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GNT_SOF, GNT_SEND, GNT_DIR} state_t;

    state_t r_state;
    logic   r_gnt_sof, r_gnt_send, r_gnt_dir, r_err;
    logic   w_send_ok, w_bad_wen;

`ifdef HC_TX_ARB_SOF_GUARD_EN
    assign w_send_ok = bus.SOFTimer < SOF_GUARD_START;
`else
    logic w_unused;
    assign w_unused  = ^{bus.SOFTimer, SOF_GUARD_START};
    assign w_send_ok = 1'b1;
`endif

    assign w_bad_wen = (bus.SOFCntlWEn & ~r_gnt_sof) | (bus.SendPktWEn & ~r_gnt_send) |
                       (bus.DirCntlWEn & ~r_gnt_dir);

    // grant FSM: grant from IDLE by priority, hold until owner drops Req, always pass through IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_gnt_sof  <= 1'b0;
            r_gnt_send <= 1'b0;
            r_gnt_dir  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= r_err | w_bad_wen;
            case (r_state)
                IDLE: begin
                    if (bus.SOFCntlReq) begin
                        r_state   <= GNT_SOF;
                        r_gnt_sof <= 1'b1;
                    end else if (bus.SendPktReq && w_send_ok) begin
                        r_state    <= GNT_SEND;
                        r_gnt_send <= 1'b1;
                    end else if (bus.DirCntlReq) begin
                        r_state   <= GNT_DIR;
                        r_gnt_dir <= 1'b1;
                    end
                end
                GNT_SOF: if (!bus.SOFCntlReq) begin
                    r_state   <= IDLE;
                    r_gnt_sof <= 1'b0;
                end
                GNT_SEND: if (!bus.SendPktReq) begin
                    r_state    <= IDLE;
                    r_gnt_send <= 1'b0;
                end
                default: if (!bus.DirCntlReq) begin
                    r_state   <= IDLE;
                    r_gnt_dir <= 1'b0;
                end
            endcase
        end
    end

    // port mux: owner's strobe and bytes pass straight through, idle port is all zeros
    always_comb begin
        bus.HCTxPortWEn  = r_gnt_sof ? bus.SOFCntlWEn  : r_gnt_send ? bus.SendPktWEn  : r_gnt_dir ? bus.DirCntlWEn  : 1'b0;
        bus.HCTxPortData = r_gnt_sof ? bus.SOFCntlData : r_gnt_send ? bus.SendPktData : r_gnt_dir ? bus.DirCntlData : 8'h00;
        bus.HCTxPortCntl = r_gnt_sof ? bus.SOFCntlCntl : r_gnt_send ? bus.SendPktCntl : r_gnt_dir ? bus.DirCntlCntl : 8'h00;
    end

    assign bus.SOFCntlGnt  = r_gnt_sof;
    assign bus.SendPktGnt  = r_gnt_send;
    assign bus.DirCntlGnt  = r_gnt_dir;
    assign bus.ArbProtoErr = r_err;
endmodule

// File: tb/tb_hc_tx_port_arbiter.sv
// tb_hc_tx_port_arbiter: directed scenarios plus random traffic against an owner/priority reference model
module tb_hc_tx_port_arbiter;
    localparam logic [15:0] GUARD = 16'hB800;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hc_tx_port_arbiter_if bus();
    hc_tx_port_arbiter #(.SOF_GUARD_START(GUARD)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic        req [3];
    logic        wen [3];
    logic [7:0]  dat [3];
    logic [7:0]  ctl [3];
    logic [15:0] tmr;

    assign bus.SOFCntlReq  = req[0];
    assign bus.SOFCntlWEn  = wen[0];
    assign bus.SOFCntlData = dat[0];
    assign bus.SOFCntlCntl = ctl[0];
    assign bus.SendPktReq  = req[1];
    assign bus.SendPktWEn  = wen[1];
    assign bus.SendPktData = dat[1];
    assign bus.SendPktCntl = ctl[1];
    assign bus.DirCntlReq  = req[2];
    assign bus.DirCntlWEn  = wen[2];
    assign bus.DirCntlData = dat[2];
    assign bus.DirCntlCntl = ctl[2];
    assign bus.SOFTimer    = tmr;

    int m_own = -1;
    bit m_err = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", tag, $time, act, exp);
        end
    endtask

    function automatic bit elig(input int i);
`ifdef HC_TX_ARB_SOF_GUARD_EN
        return i != 1 || tmr < GUARD;
`else
        return 1'b1;
`endif
    endfunction

    task automatic compare(input string tag);
        logic [2:0]  exp_g;
        logic [16:0] exp_p;
        exp_g = (m_own < 0) ? 3'b000 : 3'(1 << m_own);
        exp_p = (m_own < 0) ? 17'h0 : {wen[m_own], dat[m_own], ctl[m_own]};
        chk({tag, ".gnt"}, {29'h0, bus.DirCntlGnt, bus.SendPktGnt, bus.SOFCntlGnt}, {29'h0, exp_g});
        chk({tag, ".port"}, {15'h0, bus.HCTxPortWEn, bus.HCTxPortData, bus.HCTxPortCntl}, {15'h0, exp_p});
        chk({tag, ".err"}, {31'h0, bus.ArbProtoErr}, {31'h0, m_err});
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++)
            if (wen[i] && i != m_own) m_err = 1'b1;
        if (m_own < 0) begin
            for (int i = 0; i < 3; i++)
                if (m_own < 0 && req[i] && elig(i)) m_own = i;
        end else if (!req[m_own]) m_own = -1;
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        compare(tag);
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic reset_check();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        m_own = -1;
        m_err = 1'b0;
        compare("async_rst");
        @(negedge clk);
        compare("in_rst");
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0;
            wen[i] = 1'b0;
            dat[i] = 8'h00;
            ctl[i] = 8'h00;
        end
        tmr = 16'h0000;
    endtask

    initial begin
        clear_inputs();
        repeat (2) cycle("rst_hold");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) cycle("idle");

        // priority with simultaneous requests, then release order
        req[0] = 1'b1; req[1] = 1'b1; req[2] = 1'b1;
        repeat (3) cycle("prio");
        req[0] = 1'b0;
        repeat (4) cycle("prio_send");
        req[1] = 1'b0;
        repeat (3) cycle("prio_dir");
        req[2] = 1'b0;
        repeat (2) cycle("prio_end");

        // SOF request must not preempt an active sender
        req[1] = 1'b1;
        repeat (2) cycle("nopre");
        req[0] = 1'b1;
        repeat (3) cycle("nopre_hold");
        req[1] = 1'b0;
        repeat (3) cycle("nopre_rel");
        req[0] = 1'b0;
        repeat (2) cycle("nopre_end");

        // mux steering and sticky protocol error
        req[0] = 1'b1;
        repeat (2) cycle("mux_gnt");
        wen[0] = 1'b1; dat[0] = 8'h00; ctl[0] = 8'h01;
        wen[1] = 1'b1; dat[1] = 8'hA5; ctl[1] = 8'h5A;
        cycle("mux");
        wen[0] = 1'b0; wen[1] = 1'b0;
        repeat (3) cycle("mux_err");
        req[0] = 1'b0;
        repeat (2) cycle("mux_end");

        // asynchronous reset in the middle of a sender grant
        req[1] = 1'b1;
        repeat (2) cycle("rst_send");
        wen[1] = 1'b1; dat[1] = 8'h3C; ctl[1] = 8'hC3;
        cycle("rst_send_wen");
        reset_check();
        clear_inputs();
        repeat (2) cycle("post_rst");

        // guard window: sender held off, direct control allowed, sender after timer wrap
        tmr = 16'hB800; req[1] = 1'b1;
        repeat (3) cycle("guard");
        req[2] = 1'b1;
        repeat (3) cycle("guard_dir");
        tmr = 16'h0000;
        cycle("guard_clr");
        req[2] = 1'b0;
        repeat (3) cycle("guard_rel");
        req[1] = 1'b0;
        repeat (2) cycle("guard_end");
        tmr = 16'hB7FF; req[1] = 1'b1;
        repeat (2) cycle("guard_edge");
        req[1] = 1'b0;
        repeat (2) cycle("guard_edge_end");

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
                wen[i] = (i == m_own) ? 1'($urandom) : ($urandom_range(0, 199) == 0);
                dat[i] = 8'($urandom);
                ctl[i] = 8'($urandom);
            end
            case ($urandom_range(0, 4))
                0: tmr = 16'hB7FF;
                1: tmr = 16'hB800;
                2: tmr = 16'h0000;
                3: tmr = 16'hFFFF;
                default: tmr = 16'($urandom);
            endcase
            cycle("rand");
            if (n % 500 == 499) reset_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
